afu_command_credit_arbiter: RTL and testbench
=============================================

# afu_command_credit_arbiter

Credit-gated fixed-priority arbiter between the six AFU-Control command buffers (restart, WED, write, prefetch-write, read, prefetch-read) and the single PSL command port. It tracks separate read-class and write-class credit pools, grants at most one command per cycle, and issues it registered to the PSL command interface. Each pool is replenished by response-return pulses.

## Interface
Parameters:
- NUM_REQ, 6, number of requesters; index equals PRIORITY_* value, 0 = highest.
- CMD_BITS, 128, opaque command payload width.
- CREDITS_READ, 32, read-class pool size.
- CREDITS_WRITE, 32, write-class pool size; CREDITS_READ + CREDITS_WRITE ≤ 64.

Ports:
- clock  in  1  single clock.
- rstn  in  1  asynchronous, active-low reset.
- enabled  in  1  arbitration enable.
- req_valid  in  NUM_REQ  per-buffer command pending.
- req_cmd  in  NUM_REQ×CMD_BITS  per-buffer payload.
- req_grant  out  NUM_REQ  one-hot dequeue pulse.
- cmd_out_valid  out  1  command issue strobe.
- cmd_out  out  CMD_BITS  issued payload.
- cmd_out_src  out  3  index of granted requester.
- read_credit_return  in  1  one read-class response retired.
- write_credit_return  in  1  one write-class response retired.
- read_credits  out  $clog2(CREDITS_READ+1)  available read credits.
- write_credits  out  $clog2(CREDITS_WRITE+1)  available write credits.
- credit_error  out  1  sticky overflow flag.

## Operation
- Class map:
  - read class: RESTART(0), WED(1), READ(4), PREFETCH_READ(5).
  - write class: WRITE(2), PREFETCH_WRITE(3).
- Eligible(i) = enabled & req_valid[i] & (credits of class(i) > 0).
- The lowest-index eligible requester wins. req_grant is one-hot or all-zero.
- A grant decrements its class counter by 1.
- A return pulse increments its class counter by 1.
- Grant and return on the same class in the same cycle leave the counter unchanged.
- A return while the counter equals its pool size does not change the counter and sets credit_error. credit_error clears only on reset.
- A grant at 0 credits is impossible by construction. The bench asserts that counters never go below 0.
- With enabled low, no grants occur; returns are still accepted.
- Returns for both classes in the same cycle are both applied.

## Timing
- req_grant is combinational from req_valid, enabled and the registered counters in cycle N. The requester dequeues on that edge.
- cmd_out, cmd_out_src and cmd_out_valid are registered and appear in cycle N+1.
- cmd_out_valid is a 1-cycle pulse per grant. Back-to-back grants give back-to-back pulses, a sustained throughput of 1 command per cycle.
- Counter updates are visible on read_credits/write_credits in cycle N+1.
- A credit returned in cycle N can enable a grant in cycle N+1. It cannot enable a grant in cycle N.
- Reset values:
  - cmd_out_valid = 0, cmd_out = 0, cmd_out_src = 0, req_grant = 0.
  - read_credits = CREDITS_READ, write_credits = CREDITS_WRITE, credit_error = 0.
- Reset asserted mid-operation:
  - The pending registered command is dropped.
  - Credits reload to full, regardless of outstanding responses.

## Structure
- Shared package (GLOBALS_AFU_PKG) holds:
  - the PRIORITY_* indices and CREDITS_READ/CREDITS_WRITE;
  - a new `cmd_class_t` enum {CMD_CLASS_READ, CMD_CLASS_WRITE};
  - a constant NUM_REQ-bit class mask, 1 = write class.
- One sub-module: `fixed_priority_arbiter`. It is a parameterized, combinational lowest-index one-hot picker, reusable by the response and data paths.
- The credit counters and output registers stay in the top module.

## Test plan
- Reset then all six requesters valid → grant order 0,1,2,3,4,5 in consecutive cycles (each dropping valid after grant); cmd_out_src follows one cycle later; read_credits = 28, write_credits = 30.
- READ alone valid for 40 cycles, no returns → 32 grants, then grant held 0; read_credits = 0; one read_credit_return → exactly one more grant on the next cycle.
- read_credits = 0 with READ and WRITE valid → WRITE granted immediately; READ waits until a return.
- Grant and read_credit_return in the same cycle at read_credits = 10 → remains 10.
- write_credit_return at write_credits = 32 → stays 32; credit_error = 1 and stays 1 until rstn is pulsed.
- enabled = 0 with all valid for 5 cycles → no grants, counters unchanged. rstn asserted mid-burst → outputs zero immediately and credits reload to 32/32.

Source files
------------

// File: rtl/afu_command_credit_arbiter_pkg.sv
// rtl/afu_command_credit_arbiter_pkg.sv - shared AFU command priorities, credit pools and class map
package GLOBALS_AFU_PKG;

  localparam int AFU_NUM_REQ             = 6;
  localparam int PRIORITY_RESTART        = 0;
  localparam int PRIORITY_WED            = 1;
  localparam int PRIORITY_WRITE          = 2;
  localparam int PRIORITY_PREFETCH_WRITE = 3;
  localparam int PRIORITY_READ           = 4;
  localparam int PRIORITY_PREFETCH_READ  = 5;

  localparam int CREDITS_READ  = 32;
  localparam int CREDITS_WRITE = 32;

  typedef enum logic {
    CMD_CLASS_READ  = 1'b0,
    CMD_CLASS_WRITE = 1'b1
  } cmd_class_t;

  // Bit set = requester consumes a write-class credit.
  localparam logic [AFU_NUM_REQ-1:0] WRITE_CLASS_MASK =
    AFU_NUM_REQ'((1 << PRIORITY_WRITE) | (1 << PRIORITY_PREFETCH_WRITE));

endpackage

// File: rtl/afu_command_credit_arbiter_fixed_priority_arbiter.sv
// rtl/afu_command_credit_arbiter_fixed_priority_arbiter.sv - combinational lowest-index one-hot picker
module fixed_priority_arbiter #(
  parameter int N = 6
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Isolate the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/afu_command_credit_arbiter.sv
// rtl/afu_command_credit_arbiter.sv - credit-gated fixed-priority arbiter feeding the PSL command port
module afu_command_credit_arbiter #(
  parameter int NUM_REQ       = GLOBALS_AFU_PKG::AFU_NUM_REQ,
  parameter int CMD_BITS      = 128,
  parameter int CREDITS_READ  = GLOBALS_AFU_PKG::CREDITS_READ,
  parameter int CREDITS_WRITE = GLOBALS_AFU_PKG::CREDITS_WRITE
) (
  input  logic                                clock,
  input  logic                                rstn,
  input  logic                                enabled,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*CMD_BITS-1:0]         req_cmd,
  output logic [NUM_REQ-1:0]                  req_grant,
  output logic                                cmd_out_valid,
  output logic [CMD_BITS-1:0]                 cmd_out,
  output logic [2:0]                          cmd_out_src,
  input  logic                                read_credit_return,
  input  logic                                write_credit_return,
  output logic [$clog2(CREDITS_READ+1)-1:0]   read_credits,
  output logic [$clog2(CREDITS_WRITE+1)-1:0]  write_credits,
  output logic                                credit_error
);
  import GLOBALS_AFU_PKG::*;

  localparam int RW = $clog2(CREDITS_READ + 1);
  localparam int WW = $clog2(CREDITS_WRITE + 1);
  localparam logic [NUM_REQ-1:0] WR_MASK = NUM_REQ'(WRITE_CLASS_MASK);

  logic [RW-1:0]       rd_credits_q, rd_credits_d;
  logic [WW-1:0]       wr_credits_q, wr_credits_d;
  logic                err_q, err_d;
  logic                valid_q;
  logic [CMD_BITS-1:0] cmd_q, sel_cmd;
  logic [2:0]          src_q, sel_src;
  logic [NUM_REQ-1:0]  eligible, grant;
  cmd_class_t          req_class [NUM_REQ];
  logic                rd_avail, wr_avail, rd_grant, wr_grant;

  assign rd_avail = (rd_credits_q != '0);
  assign wr_avail = (wr_credits_q != '0);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_class[i] = WR_MASK[i] ? CMD_CLASS_WRITE : CMD_CLASS_READ;
      eligible[i]  = rstn & enabled & req_valid[i] &
                     ((req_class[i] == CMD_CLASS_WRITE) ? wr_avail : rd_avail);
    end
  end

  fixed_priority_arbiter #(.N(NUM_REQ)) u_pick (
    .req_i (eligible),
    .gnt_o (grant)
  );

  assign req_grant = grant;
  assign wr_grant  = |(grant & WR_MASK);
  assign rd_grant  = |(grant & ~WR_MASK);

  always_comb begin
    sel_cmd = '0;
    sel_src = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_cmd = req_cmd[i*CMD_BITS +: CMD_BITS];
        sel_src = 3'(i);
      end
    end
  end

  // Grant and return on the same pool cancel; a return into a full pool is dropped and flagged.
  always_comb begin
    rd_credits_d = rd_credits_q;
    wr_credits_d = wr_credits_q;
    err_d        = err_q;
    case ({rd_grant, read_credit_return})
      2'b10: rd_credits_d = rd_credits_q - RW'(1);
      2'b01: begin
        if (rd_credits_q == RW'(CREDITS_READ)) err_d = 1'b1;
        else rd_credits_d = rd_credits_q + RW'(1);
      end
      default: ;
    endcase
    case ({wr_grant, write_credit_return})
      2'b10: wr_credits_d = wr_credits_q - WW'(1);
      2'b01: begin
        if (wr_credits_q == WW'(CREDITS_WRITE)) err_d = 1'b1;
        else wr_credits_d = wr_credits_q + WW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_credits_q <= RW'(CREDITS_READ);
      wr_credits_q <= WW'(CREDITS_WRITE);
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      cmd_q        <= '0;
      src_q        <= '0;
    end else begin
      rd_credits_q <= rd_credits_d;
      wr_credits_q <= wr_credits_d;
      err_q        <= err_d;
      valid_q      <= |grant;
      if (|grant) begin
        cmd_q <= sel_cmd;
        src_q <= sel_src;
      end
    end
  end

  assign cmd_out_valid = valid_q;
  assign cmd_out       = cmd_q;
  assign cmd_out_src   = src_q;
  assign read_credits  = rd_credits_q;
  assign write_credits = wr_credits_q;
  assign credit_error  = err_q;

endmodule

// File: tb/tb_afu_command_credit_arbiter.sv
// tb/tb_afu_command_credit_arbiter.sv - scoreboard bench for the AFU command credit arbiter
module tb_afu_command_credit_arbiter;

  logic         clock = 1'b0;
  logic         rstn;
  logic         enabled;
  logic [5:0]   req_valid;
  logic [767:0] req_cmd;
  logic [5:0]   req_grant;
  logic         cmd_out_valid;
  logic [127:0] cmd_out;
  logic [2:0]   cmd_out_src;
  logic         read_credit_return;
  logic         write_credit_return;
  logic [5:0]   read_credits;
  logic [5:0]   write_credits;
  logic         credit_error;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]   src;
    logic [127:0] cmd;
  } exp_t;
  exp_t exp_q [$];

  afu_command_credit_arbiter dut (
    .clock               (clock),
    .rstn                (rstn),
    .enabled             (enabled),
    .req_valid           (req_valid),
    .req_cmd             (req_cmd),
    .req_grant           (req_grant),
    .cmd_out_valid       (cmd_out_valid),
    .cmd_out             (cmd_out),
    .cmd_out_src         (cmd_out_src),
    .read_credit_return  (read_credit_return),
    .write_credit_return (write_credit_return),
    .read_credits        (read_credits),
    .write_credits       (write_credits),
    .credit_error        (credit_error)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] cmd_pat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i), 32'(i * 3), 32'hFFFF_0000 | 32'(i)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle: inputs already set; check the grant mid-cycle, queue the expected issue, advance.
  task automatic cyc(input logic [5:0] exp_grant);
    exp_t e;
    @(negedge clock);
    check("req_grant", req_grant, exp_grant);
    for (int i = 0; i < 6; i++) begin
      if (exp_grant[i]) begin
        e.src = 3'(i);
        e.cmd = cmd_pat(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_credits(input string name, input int rd, input int wr, input logic err);
    check({name, "_rd"}, 128'(read_credits), 128'(rd));
    check({name, "_wr"}, 128'(write_credits), 128'(wr));
    check({name, "_err"}, 128'(credit_error), 128'(err));
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a command.
  always @(negedge clock) begin
    exp_t e;
    if (rstn === 1'b1) begin
      check("credit_bound", 128'((read_credits <= 6'd32) && (write_credits <= 6'd32)), 128'(1));
      if (cmd_out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 128'(cmd_out_src), 128'(7));
        end else begin
          e = exp_q.pop_front();
          check("cmd_out_src", 128'(cmd_out_src), 128'(e.src));
          check("cmd_out", cmd_out, e.cmd);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0;
    enabled = 1'b1;
    req_valid = 6'h3F;
    read_credit_return = 1'b0;
    write_credit_return = 1'b0;
    for (int i = 0; i < 6; i++) req_cmd[i*128 +: 128] = cmd_pat(i);

    // Reset state, with every requester pending.
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant", 128'(req_grant), 128'(0));
    check("rst_valid", 128'(cmd_out_valid), 128'(0));
    check("rst_cmd", cmd_out, 128'(0));
    check("rst_src", 128'(cmd_out_src), 128'(0));
    check_credits("rst", 32, 32, 1'b0);
    rstn = 1'b1;

    // Priority order, each requester dropping valid after its grant.
    for (int i = 0; i < 6; i++) begin
      cyc(6'(1 << i));
      req_valid[i] = 1'b0;
    end
    check_credits("order", 28, 30, 1'b0);
    cyc(6'b0);

    rstn = 1'b0;
    #1;
    rstn = 1'b1;

    // Drain the read pool.
    req_valid = 6'b010000;
    for (int k = 0; k < 40; k++) cyc((k < 32) ? 6'b010000 : 6'b0);
    check_credits("drain", 0, 32, 1'b0);
    read_credit_return = 1'b1;
    cyc(6'b0);
    read_credit_return = 1'b0;
    cyc(6'b010000);
    cyc(6'b0);
    check_credits("one_more", 0, 32, 1'b0);

    // Write bypasses a starved read.
    req_valid = 6'b010100;
    cyc(6'b000100);
    req_valid = 6'b010000;
    cyc(6'b0);
    cyc(6'b0);
    read_credit_return = 1'b1;
    cyc(6'b0);
    read_credit_return = 1'b0;
    cyc(6'b010000);
    req_valid = 6'b0;
    check_credits("bypass", 0, 31, 1'b0);

    // Refill to 10, then grant and return in the same cycle.
    read_credit_return = 1'b1;
    repeat (10) cyc(6'b0);
    check_credits("refill", 10, 31, 1'b0);
    req_valid = 6'b010000;
    cyc(6'b010000);
    req_valid = 6'b0;
    read_credit_return = 1'b0;
    check_credits("cancel", 10, 31, 1'b0);

    // Dual return, then overflow of the write pool.
    read_credit_return = 1'b1;
    write_credit_return = 1'b1;
    cyc(6'b0);
    read_credit_return = 1'b0;
    check_credits("dual_ret", 11, 32, 1'b0);
    cyc(6'b0);
    write_credit_return = 1'b0;
    check_credits("overflow", 11, 32, 1'b1);
    repeat (3) cyc(6'b0);
    check_credits("sticky", 11, 32, 1'b1);

    // Disabled arbitration.
    enabled = 1'b0;
    req_valid = 6'h3F;
    repeat (5) cyc(6'b0);
    check_credits("disabled", 11, 32, 1'b1);

    // Reset in the middle of a burst drops the pending issue.
    enabled = 1'b1;
    cyc(6'b000001);
    cyc(6'b000001);
    rstn = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("mid_rst_valid", 128'(cmd_out_valid), 128'(0));
    check("mid_rst_cmd", cmd_out, 128'(0));
    check("mid_rst_src", 128'(cmd_out_src), 128'(0));
    check("mid_rst_grant", 128'(req_grant), 128'(0));
    check_credits("mid_rst", 32, 32, 1'b0);
    req_valid = 6'b0;
    @(posedge clock);
    #1;
    rstn = 1'b1;
    cyc(6'b0);
    cyc(6'b0);

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
